// File: rtl/polytris_pkg.sv
// polytris_pkg: keycodes shared with the game state machine and the repeat FSM state type.
package polytris_pkg;
    localparam logic [7:0] KEY_LEFT   = 8'h04;
    localparam logic [7:0] KEY_RIGHT  = 8'h07;
    localparam logic [7:0] KEY_ROT_L  = 8'h14;
    localparam logic [7:0] KEY_ROT_R  = 8'h1a;
    localparam logic [7:0] KEY_SOFT   = 8'h16;
    localparam logic [7:0] KEY_HOLD   = 8'h0f;
    localparam logic [7:0] KEY_HARD   = 8'h2c;
    localparam logic [7:0] KEY_KONAMI = 8'h18;
    typedef enum logic [1:0] {S_IDLE, S_DAS, S_ARR} rep_state_t;
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: free-running prescaler, one-cycle tick every TICK_DIV clocks.
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic CLK,
    input  logic RESET,
    output logic tick
);
    localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge CLK) begin
        if (RESET) cnt <= '0;
        else       cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
    assign tick = cnt == LAST;
endmodule

// File: rtl/key_repeat_ctrl.sv
// key_repeat_ctrl: keycode to pending event flags with DAS/ARR auto-repeat on LEFT/RIGHT.
module key_repeat_ctrl
    import polytris_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int DAS_MS   = 170,
    parameter int ARR_MS   = 50
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] keyboardinput,
    input  logic       ack_left,
    input  logic       ack_right,
    input  logic       ack_rotl,
    input  logic       ack_rotr,
    input  logic       ack_hold,
    input  logic       ack_hard,
    input  logic       ack_konami,
    output logic       ev_left,
    output logic       ev_right,
    output logic       ev_rotl,
    output logic       ev_rotr,
    output logic       ev_hold,
    output logic       ev_hard,
    output logic       ev_konami,
    output logic       soft_drop,
    output logic       repeat_active
);
    localparam logic [7:0] DAS_END = 8'(DAS_MS - 1);
    localparam logic [7:0] ARR_END = 8'(ARR_MS - 1);
    logic [7:0] key_q, key_prev, ms_cnt, cnt_n;
    logic [6:0] ev, fire, ack;
    rep_state_t state, state_n;
    logic tick, press, rep;
    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.CLK(CLK), .RESET(RESET), .tick(tick));
    assign ack = {ack_konami, ack_hard, ack_hold, ack_rotr, ack_rotl, ack_right, ack_left};
    assign {ev_konami, ev_hard, ev_hold, ev_rotr, ev_rotl, ev_right, ev_left} = ev;
    assign press = key_q != key_prev && key_q != 8'h00;
    always_comb begin
        state_n = state;
        cnt_n   = ms_cnt;
        rep     = 1'b0;
        // A direction press restarts DAS from any state, including a direct LEFT<->RIGHT swap
        if (press && (key_q == KEY_LEFT || key_q == KEY_RIGHT)) begin
            rep     = 1'b1;
            state_n = S_DAS;
            cnt_n   = 8'h00;
        end else if (state != S_IDLE && key_q != key_prev) begin
            state_n = S_IDLE;
        end else if (state != S_IDLE && tick) begin
            if (ms_cnt == (state == S_DAS ? DAS_END : ARR_END)) begin
                rep     = 1'b1;
                state_n = S_ARR;
                cnt_n   = 8'h00;
            end else begin
                cnt_n = (ms_cnt == 8'hFF) ? ms_cnt : ms_cnt + 8'h01;
            end
        end
        fire = {press && key_q == KEY_KONAMI, press && key_q == KEY_HARD, press && key_q == KEY_HOLD,
                press && key_q == KEY_ROT_R, press && key_q == KEY_ROT_L,
                rep && key_q == KEY_RIGHT, rep && key_q == KEY_LEFT};
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            key_q         <= 8'h00;
            key_prev      <= 8'h00;
            state         <= S_IDLE;
            ms_cnt        <= 8'h00;
            ev            <= '0;
            soft_drop     <= 1'b0;
            repeat_active <= 1'b0;
        end else begin
            key_prev      <= key_q;
            key_q         <= keyboardinput;
            soft_drop     <= keyboardinput == KEY_SOFT;
            state         <= state_n;
            ms_cnt        <= cnt_n;
            repeat_active <= state_n == S_ARR;
            ev            <= fire | (ev & ~ack);
        end
    end
endmodule
